// File: rtl/multicycle_control_unit_if.sv
// multicycle_control_unit_if
// Bundles the instruction-fetch handshake, the datapath status inputs and
// all datapath control outputs of the multi-cycle control unit.
//   master : the control unit (consumes instr/instr_valid/EQ/mem_ready,
//            drives instr_ready, datapath enables, status and counter)
//   slave  : the surrounding core / environment
// Parameters ALU_CTRL_W, IMM_SRC_W and CNT_W must match the control unit.
interface multicycle_control_unit_if #(
  parameter int ALU_CTRL_W = 3,
  parameter int IMM_SRC_W  = 2,
  parameter int CNT_W      = 16
);
  logic [31:0]           instr;
  logic                  instr_valid;
  logic                  instr_ready;
  logic                  EQ;
  logic                  mem_ready;
  logic                  RegWrite;
  logic [ALU_CTRL_W-1:0] ALUctrl;
  logic                  ALUsrc;
  logic [IMM_SRC_W-1:0]  ImmSrc;
  logic                  PCsrc;
  logic                  PCen;
  logic                  MemRead;
  logic                  MemWrite;
  logic                  ResultSrc;
  logic                  mem_timeout;
  logic                  illegal;
  logic [CNT_W-1:0]      instr_count;

  modport master (
    input  instr, instr_valid, EQ, mem_ready,
    output instr_ready, RegWrite, ALUctrl, ALUsrc, ImmSrc, PCsrc, PCen,
           MemRead, MemWrite, ResultSrc, mem_timeout, illegal, instr_count
  );

  modport slave (
    output instr, instr_valid, EQ, mem_ready,
    input  instr_ready, RegWrite, ALUctrl, ALUsrc, ImmSrc, PCsrc, PCen,
           MemRead, MemWrite, ResultSrc, mem_timeout, illegal, instr_count
  );
endinterface

// File: rtl/multicycle_control_unit.sv
// multicycle_control_unit
// Registered multi-cycle control FSM for the reduced RISC-V core
// (addi/andi, add/sub, beq/bne, lw/sw): IDLE -> DECODE -> EXEC -> MEM -> WB.
// Ports:
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset; all outputs forced to 0 while high
//   bus  : multicycle_control_unit_if.master - fetch handshake, EQ flag,
//          mem_ready, datapath enables, mem_timeout, illegal, instr_count
// Optional feature macro: ILLEGAL_TRAP_EN - an illegal instruction parks the
// FSM in TRAP (sticky illegal, no strobes, no instr_ready) until reset.
module multicycle_control_unit #(
  parameter int ALU_CTRL_W   = 3,
  parameter int IMM_SRC_W    = 2,
  parameter int MEM_WAIT_MAX = 15,
  parameter int CNT_W        = 16
) (
  input logic                       clk,
  input logic                       rst,
  multicycle_control_unit_if.master bus
);
  localparam int WAIT_W = 8;
  localparam logic [ALU_CTRL_W-1:0] ALU_ADD = '0;
  localparam logic [ALU_CTRL_W-1:0] ALU_SUB = ALU_CTRL_W'(1);
  localparam logic [ALU_CTRL_W-1:0] ALU_AND = ALU_CTRL_W'(2);
  localparam logic [IMM_SRC_W-1:0]  IMM_I   = '0;
  localparam logic [IMM_SRC_W-1:0]  IMM_S   = IMM_SRC_W'(1);
  localparam logic [IMM_SRC_W-1:0]  IMM_B   = IMM_SRC_W'(2);

  typedef enum logic [2:0] {
    IDLE, DECODE, EXEC, MEM, WB
`ifdef ILLEGAL_TRAP_EN
    , TRAP
`endif
  } state_t;

  state_t              state_reg, state_next;
  logic [31:0]         instr_reg;
  logic [WAIT_W-1:0]   wait_reg, wait_next;
  logic [CNT_W-1:0]    count_reg;
  logic                retire;

  // Decode fields of the latched instruction only.
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       funct7_b5;
  logic       is_alui, is_alur, is_branch, is_lw, is_sw, is_beq, is_legal;
  logic [ALU_CTRL_W-1:0] alu_op_ctrl;

  assign opcode    = instr_reg[6:0];
  assign funct3    = instr_reg[14:12];
  assign funct7_b5 = instr_reg[30];

  assign is_alui   = (opcode == 7'b0010011) && (funct3 == 3'b000 || funct3 == 3'b111);
  assign is_alur   = (opcode == 7'b0110011) && (funct3 == 3'b000);
  assign is_branch = (opcode == 7'b1100011) && (funct3 == 3'b000 || funct3 == 3'b001);
  assign is_lw     = (opcode == 7'b0000011) && (funct3 == 3'b010);
  assign is_sw     = (opcode == 7'b0100011) && (funct3 == 3'b010);
  assign is_beq    = (funct3 == 3'b000);
  assign is_legal  = is_alui | is_alur | is_branch | is_lw | is_sw;

  // andi is the only funct3=111 op; sub only exists in the register form.
  assign alu_op_ctrl = (funct3 == 3'b111)          ? ALU_AND :
                       (is_alur && funct7_b5)      ? ALU_SUB : ALU_ADD;

  // Register indices and immediates belong to the datapath, not to control.
  logic unused_fields;
  assign unused_fields = &{1'b0, instr_reg[31], instr_reg[29:15], instr_reg[11:7]};

  // Unmasked outputs, decoded from state_reg/instr_reg (plus EQ, mem_ready).
  logic                  instr_ready_d, reg_write_d, alu_src_d, pc_src_d, pc_en_d;
  logic                  mem_read_d, mem_write_d, result_src_d, timeout_d, illegal_d;
  logic [ALU_CTRL_W-1:0] alu_ctrl_d;
  logic [IMM_SRC_W-1:0]  imm_src_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      instr_reg <= '0;
      wait_reg  <= '0;
      count_reg <= '0;
    end else begin
      state_reg <= state_next;
      wait_reg  <= wait_next;
      if (state_reg == IDLE && bus.instr_valid)
        instr_reg <= bus.instr;
      if (retire)
        count_reg <= count_reg + 1'b1;
    end
  end

  always_comb begin
    state_next    = state_reg;
    wait_next     = wait_reg;
    retire        = 1'b0;
    instr_ready_d = 1'b0;
    reg_write_d   = 1'b0;
    alu_ctrl_d    = ALU_ADD;
    alu_src_d     = 1'b0;
    imm_src_d     = IMM_I;
    pc_src_d      = 1'b0;
    pc_en_d       = 1'b0;
    mem_read_d    = 1'b0;
    mem_write_d   = 1'b0;
    result_src_d  = 1'b0;
    timeout_d     = 1'b0;
    illegal_d     = 1'b0;
    case (state_reg)
      IDLE: begin
        instr_ready_d = 1'b1;
        if (bus.instr_valid)
          state_next = DECODE;
      end
      DECODE: begin
        if (!is_legal) begin
          illegal_d = 1'b1;
`ifdef ILLEGAL_TRAP_EN
          state_next = TRAP;
`else
          pc_en_d    = 1'b1;   // skip to PC+4 without retiring
          state_next = IDLE;
`endif
        end else begin
          state_next = EXEC;
        end
      end
      EXEC: begin
        if (is_branch) begin
          alu_ctrl_d = ALU_SUB;
          imm_src_d  = IMM_B;
          pc_en_d    = 1'b1;
          pc_src_d   = is_beq ? bus.EQ : !bus.EQ;
          retire     = 1'b1;
          state_next = IDLE;
        end else if (is_lw || is_sw) begin
          alu_ctrl_d = ALU_ADD;
          alu_src_d  = 1'b1;
          imm_src_d  = is_sw ? IMM_S : IMM_I;
          wait_next  = '0;
          state_next = MEM;
        end else begin
          alu_ctrl_d = alu_op_ctrl;
          alu_src_d  = is_alui;
          state_next = WB;
        end
      end
      MEM: begin
        mem_read_d  = is_lw;
        mem_write_d = is_sw;
        if (bus.mem_ready) begin
          // Completion takes priority over a timeout in the same cycle.
          if (is_sw) begin
            pc_en_d    = 1'b1;
            retire     = 1'b1;
            state_next = IDLE;
          end else begin
            state_next = WB;
          end
        end else if (wait_reg == WAIT_W'(MEM_WAIT_MAX)) begin
          timeout_d  = 1'b1;
          pc_en_d    = 1'b1;
          state_next = IDLE;
        end else begin
          wait_next = wait_reg + 1'b1;
        end
      end
      WB: begin
        reg_write_d  = 1'b1;
        result_src_d = is_lw;
        pc_en_d      = 1'b1;
        retire       = 1'b1;
        state_next   = IDLE;
      end
`ifdef ILLEGAL_TRAP_EN
      TRAP: begin
        illegal_d = 1'b1;
      end
`endif
      default: state_next = IDLE;
    endcase
  end

  // Reset masks every output in the same cycle it is asserted, so an
  // aborted access never shows a partial strobe.
  assign bus.instr_ready = !rst && instr_ready_d;
  assign bus.RegWrite    = !rst && reg_write_d;
  assign bus.ALUctrl     = rst ? '0 : alu_ctrl_d;
  assign bus.ALUsrc      = !rst && alu_src_d;
  assign bus.ImmSrc      = rst ? '0 : imm_src_d;
  assign bus.PCsrc       = !rst && pc_src_d;
  assign bus.PCen        = !rst && pc_en_d;
  assign bus.MemRead     = !rst && mem_read_d;
  assign bus.MemWrite    = !rst && mem_write_d;
  assign bus.ResultSrc   = !rst && result_src_d;
  assign bus.mem_timeout = !rst && timeout_d;
  assign bus.illegal     = !rst && illegal_d;
  assign bus.instr_count = rst ? '0 : count_reg;
endmodule

// File: tb/tb_multicycle_control_unit.sv
// tb_multicycle_control_unit
// Directed stimulus for multicycle_control_unit. Each stimulus cycle pushes
// the hand-computed expected output snapshot for that cycle into a queue;
// an independent monitor pops and compares one snapshot per cycle.
module tb_multicycle_control_unit;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  multicycle_control_unit_if #(.ALU_CTRL_W(3), .IMM_SRC_W(2), .CNT_W(16)) bus ();

  multicycle_control_unit #(
    .ALU_CTRL_W(3), .IMM_SRC_W(2), .MEM_WAIT_MAX(15), .CNT_W(16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct packed {
    logic        instr_ready;
    logic        RegWrite;
    logic [2:0]  ALUctrl;
    logic        ALUsrc;
    logic [1:0]  ImmSrc;
    logic        PCsrc;
    logic        PCen;
    logic        MemRead;
    logic        MemWrite;
    logic        ResultSrc;
    logic        mem_timeout;
    logic        illegal;
    logic [15:0] instr_count;
  } out_t;

  out_t  exp_q[$];
  string name_q[$];
  int    errors = 0;
  int    checks = 0;
  int    exp_cnt = 0;

  // Monitor: one comparison per cycle that has a pending expectation.
  initial begin
    out_t  e, act;
    string n;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n = name_q.pop_front();
        act.instr_ready = bus.instr_ready;
        act.RegWrite    = bus.RegWrite;
        act.ALUctrl     = bus.ALUctrl;
        act.ALUsrc      = bus.ALUsrc;
        act.ImmSrc      = bus.ImmSrc;
        act.PCsrc       = bus.PCsrc;
        act.PCen        = bus.PCen;
        act.MemRead     = bus.MemRead;
        act.MemWrite    = bus.MemWrite;
        act.ResultSrc   = bus.ResultSrc;
        act.mem_timeout = bus.mem_timeout;
        act.illegal     = bus.illegal;
        act.instr_count = bus.instr_count;
        checks++;
        if (act !== e) begin
          errors++;
          $display("FAIL %s: got %h expected %h (rdy,rw,alu[3],src,imm[2],pcs,pce,mr,mw,res,to,ill,cnt[16])",
                   n, act, e);
        end
      end
    end
  end

  function automatic out_t z();
    out_t r;
    r = '0;
    r.instr_count = 16'(exp_cnt);
    return r;
  endfunction

  function automatic out_t idle();
    out_t r;
    r = z();
    r.instr_ready = 1'b1;
    return r;
  endfunction

  task automatic cyc(input string nm, input logic [31:0] i, input logic v,
                     input logic eq, input logic mr, input logic r, input out_t e);
    @(posedge clk);
    #1;
    bus.instr       = i;
    bus.instr_valid = v;
    bus.EQ          = eq;
    bus.mem_ready   = mr;
    rst             = r;
    name_q.push_back(nm);
    exp_q.push_back(e);
  endtask

  task automatic do_alu(input string nm, input logic [31:0] i,
                        input logic alusrc, input logic [2:0] ctl);
    out_t e;
    cyc({nm, " accept"}, i, 1, 0, 0, 0, idle());
    cyc({nm, " decode"}, 32'h0, 0, 0, 0, 0, z());
    e = z(); e.ALUctrl = ctl; e.ALUsrc = alusrc;
    // instr_valid outside IDLE must be ignored
    cyc({nm, " exec"}, 32'hFFFF_FFFF, 1, 0, 0, 0, e);
    e = z(); e.RegWrite = 1; e.PCen = 1;
    cyc({nm, " wb"}, 32'h0, 0, 0, 0, 0, e);
    exp_cnt++;
  endtask

  task automatic do_branch(input string nm, input logic [31:0] i,
                           input logic eq, input logic taken);
    out_t e;
    cyc({nm, " accept"}, i, 1, 0, 0, 0, idle());
    cyc({nm, " decode"}, 32'h0, 0, eq, 0, 0, z());
    e = z(); e.ALUctrl = 3'b001; e.ImmSrc = 2'b10; e.PCen = 1; e.PCsrc = taken;
    cyc({nm, " exec"}, 32'h0, 0, eq, 0, 0, e);
    exp_cnt++;
  endtask

  task automatic do_mem_front(input string nm, input logic [31:0] i, input logic is_lw);
    out_t e;
    cyc({nm, " accept"}, i, 1, 0, 0, 0, idle());
    cyc({nm, " decode"}, 32'h0, 0, 0, 0, 0, z());
    e = z(); e.ALUsrc = 1; e.ImmSrc = is_lw ? 2'b00 : 2'b01;
    cyc({nm, " exec"}, 32'h0, 0, 0, 0, 0, e);
  endtask

  task automatic do_mem(input string nm, input logic [31:0] i,
                        input logic is_lw, input int waits);
    out_t e;
    do_mem_front(nm, i, is_lw);
    for (int k = 0; k < waits; k++) begin
      e = z(); e.MemRead = is_lw; e.MemWrite = !is_lw;
      cyc({nm, " mem wait"}, 32'h0, 0, 0, 0, 0, e);
    end
    e = z(); e.MemRead = is_lw; e.MemWrite = !is_lw; e.PCen = !is_lw;
    cyc({nm, " mem done"}, 32'h0, 0, 0, 1, 0, e);
    if (is_lw) begin
      e = z(); e.RegWrite = 1; e.ResultSrc = 1; e.PCen = 1;
      cyc({nm, " wb"}, 32'h0, 0, 0, 0, 0, e);
    end
    exp_cnt++;
  endtask

  initial begin
    out_t e;
    bus.instr = '0; bus.instr_valid = 0; bus.EQ = 0; bus.mem_ready = 0;

    cyc("reset0", 32'h0, 1, 0, 1, 1, '0);
    cyc("reset1", 32'h0, 1, 0, 1, 1, '0);
    @(negedge clk);
    #1;
    checks++;
    if (bus.instr_ready !== 1'b0 || bus.RegWrite !== 1'b0 || bus.PCen !== 1'b0 ||
        bus.MemRead !== 1'b0 || bus.MemWrite !== 1'b0 || bus.illegal !== 1'b0 ||
        bus.instr_count !== 16'h0) begin
      errors++;
      $display("FAIL reset state: rdy=%b rw=%b pce=%b mr=%b mw=%b ill=%b cnt=%h",
               bus.instr_ready, bus.RegWrite, bus.PCen, bus.MemRead, bus.MemWrite,
               bus.illegal, bus.instr_count);
    end
    cyc("idle after reset", 32'h0, 0, 0, 0, 0, idle());

    do_alu("addi", 32'h0050_0093, 1, 3'b000);
    do_alu("andi", 32'h0070_F193, 1, 3'b010);
    do_alu("add",  32'h0030_8233, 0, 3'b000);
    do_alu("sub",  32'h4030_82B3, 0, 3'b001);

    do_branch("bne eq0", 32'h0000_9463, 0, 1);
    do_branch("bne eq1", 32'h0000_9463, 1, 0);
    do_branch("beq eq1", 32'h0000_0463, 1, 1);

    do_mem("lw 3 waits",  32'h0000_A103, 1, 3);
    do_mem("sw 0 waits",  32'h0020_A223, 0, 0);

    // sw timeout: 15 plain wait cycles, the 16th MEM cycle times out
    do_mem_front("sw timeout", 32'h0020_A223, 0);
    for (int k = 0; k < 15; k++) begin
      e = z(); e.MemWrite = 1;
      cyc("sw timeout wait", 32'h0, 0, 0, 0, 0, e);
    end
    e = z(); e.MemWrite = 1; e.mem_timeout = 1; e.PCen = 1;
    cyc("sw timeout pulse", 32'h0, 0, 0, 0, 0, e);
    @(negedge clk);
    #1;
    checks++;
    if (bus.mem_timeout !== 1'b1 || bus.PCen !== 1'b1 || bus.RegWrite !== 1'b0 ||
        bus.MemWrite !== 1'b1 || bus.instr_count !== 16'(exp_cnt)) begin
      errors++;
      $display("FAIL expired wait: to=%b pce=%b rw=%b mw=%b cnt=%h expected cnt=%h",
               bus.mem_timeout, bus.PCen, bus.RegWrite, bus.MemWrite,
               bus.instr_count, 16'(exp_cnt));
    end
    cyc("idle after timeout", 32'h0, 0, 0, 0, 0, idle());

    // mem_ready on the would-be timeout cycle completes normally
    do_mem("lw ready at limit", 32'h0000_A103, 1, 15);

    // reset during the MEM wait of an lw
    do_mem_front("lw reset", 32'h0000_A103, 1);
    e = z(); e.MemRead = 1;
    cyc("lw reset wait", 32'h0, 0, 0, 0, 0, e);
    cyc("lw reset wait", 32'h0, 0, 0, 0, 0, e);
    cyc("rst mid lw", 32'h0, 0, 0, 1, 1, '0);
    exp_cnt = 0;
    cyc("idle after mid rst", 32'h0, 0, 0, 1, 0, idle());
    cyc("no late regwrite", 32'h0, 0, 0, 1, 0, idle());
    cyc("no late regwrite", 32'h0, 0, 0, 1, 0, idle());

`ifndef ILLEGAL_TRAP_EN
    // lb (funct3=000 load) is not supported
    cyc("lb accept", 32'h0000_8103, 1, 0, 0, 0, idle());
    e = z(); e.illegal = 1; e.PCen = 1;
    cyc("lb decode skip", 32'h0, 0, 0, 0, 0, e);
    cyc("idle after lb", 32'h0, 0, 0, 0, 0, idle());
    cyc("slli accept", 32'h0010_9093, 1, 0, 0, 0, idle());
    cyc("slli decode skip", 32'h0, 0, 0, 0, 0, e);
`endif
    cyc("ill7f accept", 32'h0000_007F, 1, 0, 0, 0, idle());
    e = z(); e.illegal = 1;
`ifndef ILLEGAL_TRAP_EN
    e.PCen = 1;
`endif
    cyc("ill7f decode", 32'h0, 0, 0, 0, 0, e);
`ifdef ILLEGAL_TRAP_EN
    e = z(); e.illegal = 1;
    for (int k = 0; k < 3; k++)
      cyc("trap sticky", 32'h0050_0093, 1, 0, 1, 0, e);
    cyc("trap reset", 32'h0, 0, 0, 0, 1, '0);
`endif
    cyc("idle final", 32'h0, 0, 0, 0, 0, idle());
    do_alu("addi final", 32'h0050_0093, 1, 3'b000);
    cyc("count final", 32'h0, 0, 0, 0, 0, idle());

    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/multicycle_control_unit.md
Name: multicycle_control_unit

Overview:
- Next-generation control unit for the reduced RISC-V core.
- Replaces single-cycle combinational decoding with a registered multi-cycle FSM: FETCH handshake, DECODE, EXEC, MEM, WB.
- Supports addi/andi, add/sub, beq/bne, lw/sw, with a memory wait-state handshake, a bounded memory timeout and a retired-instruction counter.
- Sits between instruction memory, the register file/ALU datapath and data memory; drives all datapath enables.

Parameters:
- ALU_CTRL_W, 3, width of ALUctrl (minimum 3).
- IMM_SRC_W, 2, width of ImmSrc (minimum 2).
- MEM_WAIT_MAX, 15, maximum MEM-state wait cycles before timeout (1..255).
- CNT_W, 16, width of the retired-instruction counter.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous active-high reset.
- instr  in  32  instruction word, sampled when instr_valid && instr_ready.
- instr_valid  in  1  instruction word available.
- instr_ready  out  1  FSM idle, accepting an instruction.
- EQ  in  1  ALU zero/equal flag, sampled in EXEC.
- mem_ready  in  1  data memory completes the access this cycle.
- RegWrite  out  1  register file write strobe.
- ALUctrl  out  ALU_CTRL_W  000 add, 001 sub, 010 and; upper bits 0.
- ALUsrc  out  1  1 = immediate operand.
- ImmSrc  out  IMM_SRC_W  00 I-type, 01 S-type, 10 B-type.
- PCsrc  out  1  1 = PC+imm, 0 = PC+4; meaningful only while PCen=1.
- PCen  out  1  PC update strobe.
- MemRead  out  1  load request.
- MemWrite  out  1  store request.
- ResultSrc  out  1  1 = writeback from memory.
- mem_timeout  out  1  one-cycle pulse on memory timeout.
- illegal  out  1  unsupported instruction flag.
- instr_count  out  CNT_W  retired-instruction count, wraps modulo 2^CNT_W.

Behaviour:
- Reset (rst high at a clk edge): state=IDLE; instr_reg, wait counter and instr_count cleared; illegal cleared. While rst is high, every output is 0, including instr_ready.
- Outputs are decoded from the state register and instr_reg only. They never depend combinationally on instr. EQ feeds only PCsrc in EXEC. mem_ready feeds only the MEM outputs.
- Decode on instr_reg:
  - op 0010011 f3 000 = addi; f3 111 = andi.
  - op 0110011 f3 000 = add (f7[5]=0) / sub (f7[5]=1).
  - op 1100011 f3 000 = beq; f3 001 = bne.
  - op 0000011 f3 010 = lw.
  - op 0100011 f3 010 = sw.
  - Anything else is illegal.
- IDLE: instr_ready=1. When instr_valid=1, latch instr and go to DECODE. Otherwise stay.
- DECODE: exactly 1 cycle. Illegal instructions go to IDLE with PCen=1, PCsrc=0 (skip) and an illegal pulse. Legal instructions go to EXEC.
- EXEC: ALUctrl/ALUsrc/ImmSrc driven per class.
  - Branch: ALUctrl=sub, ImmSrc=10, PCen=1, PCsrc=(beq ? EQ : !EQ). Retire; go to IDLE.
  - ALU op: go to WB.
  - lw/sw: ALUctrl=add, ALUsrc=1, ImmSrc=00 (lw) or 01 (sw). Go to MEM with wait counter=0.
- MEM: MemRead (lw) or MemWrite (sw) held high until mem_ready.
  - mem_ready=1: sw retires (PCen=1) and goes to IDLE; lw goes to WB.
  - Each cycle without mem_ready increments the counter. Timeout occurs on the cycle where the counter equals MEM_WAIT_MAX and mem_ready=0: mem_timeout pulses, PCen=1, no retire, no RegWrite, go to IDLE.
  - mem_ready=1 on the timeout cycle wins: normal completion.
- WB: RegWrite=1, ResultSrc=(lw), PCen=1, PCsrc=0. Retire; go to IDLE.
- Latency: branch 3 cycles; ALU op 4 cycles; sw 4+waits; lw 5+waits (counted from the accept cycle).
- instr_count increments by 1 on each retire cycle. A timeout or an illegal skip does not retire.
- Reset asserted mid-instruction aborts it at that clock edge. No partial RegWrite/MemWrite is issued afterwards.
- instr_valid asserted outside IDLE is ignored. The source must hold it until instr_ready.

Optional Feature:
- ILLEGAL_TRAP_EN defined: an illegal instruction moves DECODE to TRAP. In TRAP, illegal=1 (sticky) and all strobes and instr_ready stay 0 until rst.
- Not defined: illegal pulses for one cycle in DECODE, the instruction is skipped (PCen=1, PCsrc=0) and the FSM returns to IDLE. TRAP does not exist.

Test Plan:
- Reset, then addi x1,x0,5 (0x00500093) with instr_valid=1 → accept, DECODE, EXEC (ALUsrc=1, ALUctrl=000, ImmSrc=00), then WB with RegWrite=1 and PCen=1; instr_count=1.
- bne x1,x0,8 (0x00009463) with EQ=0 → in EXEC: PCen=1, PCsrc=1, ALUctrl=001, ImmSrc=10. Repeat with EQ=1 → PCsrc=0.
- lw x2,0(x1) (0x0000A103), mem_ready asserted after 3 cycles → MemRead high for 4 MEM cycles, then WB with RegWrite=1 and ResultSrc=1.
- sw with mem_ready held 0, MEM_WAIT_MAX=15 → mem_timeout pulses once after the 16th MEM cycle, MemWrite drops, instr_count unchanged.
- Opcode 0x0000007F → without ILLEGAL_TRAP_EN: illegal pulse and PCen=1, then back to IDLE. With it: illegal sticky and instr_ready=0 until rst.
- rst asserted during the MEM wait of an lw → next cycle all outputs 0; after release, IDLE with instr_ready=1 and no RegWrite ever issued.
